// File: rtl/access_timer.sv
// Access-length timer: counts edges of a module's grant and pulses its done bit when the access completes.
// Optional ACCESS_TIMER_RESUME_EN keeps a preempted module's remaining count for its next grant.
module access_timer #(
    parameter int unsigned M1_LEN = 4,
    parameter int unsigned M2_LEN = 6,
    parameter int unsigned M3_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] accmodule,
    output logic [2:0] done,
    output logic       busy,
    output logic [7:0] nb_preempt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        DONE_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         owner, owner_nxt;
    logic [2:0]         done_nxt;
    logic               busy_nxt;
    logic [7:0]         nb_nxt;
    logic [CNT_W-1:0]   load_val_c;
    logic               start_c;

`ifdef ACCESS_TIMER_RESUME_EN
    logic [3:1][CNT_W-1:0] saved, saved_nxt;
    logic [3:1]            saved_vld, vld_nxt;
`endif

    function automatic logic [CNT_W-1:0] full_load(input logic [1:0] k);
        case (k)
            2'd1:    full_load = CNT_W'(M1_LEN - 1);
            2'd2:    full_load = CNT_W'(M2_LEN - 1);
            2'd3:    full_load = CNT_W'(M3_LEN - 1);
            default: full_load = '0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] k);
        onehot = (k == 2'd0) ? 3'b000 : (3'b001 << 2'(k - 2'd1));
    endfunction

    // Value loaded on the grant edge; that edge itself is the first sample of the access.
    always_comb begin
        load_val_c = full_load(accmodule);
`ifdef ACCESS_TIMER_RESUME_EN
        if (accmodule != 2'd0 && saved_vld[accmodule])
            load_val_c = saved[accmodule] - CNT_W'(1);
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        done_nxt  = 3'b000;
        nb_nxt    = nb_preempt;
        start_c   = 1'b0;
`ifdef ACCESS_TIMER_RESUME_EN
        saved_nxt = saved;
        vld_nxt   = saved_vld;
`endif
        case (state)
            IDLE: begin
                if (accmodule != 2'd0)
                    start_c = 1'b1;
            end
            COUNT: begin
                if (accmodule == owner) begin
                    if (cnt != '0)
                        cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE_WAIT;
                        done_nxt  = onehot(owner);
                    end
                end else if (accmodule == 2'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    owner_nxt = 2'd0;
`ifdef ACCESS_TIMER_RESUME_EN
                    if (owner != 2'd0)
                        vld_nxt[owner] = 1'b0;
`endif
                end else begin
                    if (nb_preempt != 8'hFF)
                        nb_nxt = nb_preempt + 8'd1;
`ifdef ACCESS_TIMER_RESUME_EN
                    if (owner != 2'd0) begin
                        saved_nxt[owner] = cnt;
                        vld_nxt[owner]   = 1'b1;
                    end
`endif
                    start_c = 1'b1;
                end
            end
            DONE_WAIT: begin
                if (accmodule == 2'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    owner_nxt = 2'd0;
                end else if (accmodule != owner) begin
                    start_c = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                owner_nxt = 2'd0;
            end
        endcase

        if (start_c) begin
            cnt_nxt   = load_val_c;
            owner_nxt = accmodule;
`ifdef ACCESS_TIMER_RESUME_EN
            if (accmodule != 2'd0)
                vld_nxt[accmodule] = 1'b0;
`endif
            if (load_val_c == '0) begin
                state_nxt = DONE_WAIT;
                done_nxt  = onehot(accmodule);
            end else begin
                state_nxt = COUNT;
            end
        end

        busy_nxt = (state_nxt == COUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 2'd0;
            done       <= 3'b000;
            busy       <= 1'b0;
            nb_preempt <= 8'd0;
`ifdef ACCESS_TIMER_RESUME_EN
            saved      <= '0;
            saved_vld  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner      <= owner_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            nb_preempt <= nb_nxt;
`ifdef ACCESS_TIMER_RESUME_EN
            saved      <= saved_nxt;
            saved_vld  <= vld_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_access_timer.sv
// Directed self-checking bench for access_timer; expectations follow ACCESS_TIMER_RESUME_EN when defined.
module tb_access_timer;

    logic       clk;
    logic       reset;
    logic [1:0] accmodule, acc_b;
    logic [2:0] done, done_b;
    logic       busy, busy_b;
    logic [7:0] nb_preempt, nb_b;

    int n_checks = 0;
    int n_fail   = 0;

    access_timer u_dut (
        .clk(clk), .reset(reset), .accmodule(accmodule),
        .done(done), .busy(busy), .nb_preempt(nb_preempt)
    );

    access_timer #(.M1_LEN(1)) u_short (
        .clk(clk), .reset(reset), .accmodule(acc_b),
        .done(done_b), .busy(busy_b), .nb_preempt(nb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] a);
        accmodule = a;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [1:0] a);
        acc_b = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m2_edges;
        int sat_grants;
        int nb_after10;
`ifdef ACCESS_TIMER_RESUME_EN
        m2_edges   = 3;
        sat_grants = 602;
        nb_after10 = 8;
`else
        m2_edges   = 6;
        sat_grants = 300;
        nb_after10 = 10;
`endif
        reset = 1'b1;
        accmodule = 2'd0;
        acc_b = 2'd0;
        #2;
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_nb", 32'(nb_preempt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // M1 held for its full length
        for (int i = 1; i <= 3; i++) begin
            step(2'd1);
            check($sformatf("m1_busy_e%0d", i), 32'(busy), 1);
            check($sformatf("m1_done_e%0d", i), 32'(done), 0);
        end
        step(2'd1);
        check("m1_done_e4", 32'(done), 32'b001);
        check("m1_busy_e4", 32'(busy), 0);
        step(2'd0);
        check("m1_done_clr", 32'(done), 0);
        check("m1_nb", 32'(nb_preempt), 0);

        // M2 preempted by M1, then M2 resumes or restarts
        for (int i = 1; i <= 3; i++) step(2'd2);
        check("pre_busy", 32'(busy), 1);
        step(2'd1);
        check("pre_nb", 32'(nb_preempt), 1);
        check("pre_busy1", 32'(busy), 1);
        for (int i = 2; i <= 3; i++) step(2'd1);
        check("pre_m1_nodone", 32'(done), 0);
        step(2'd1);
        check("pre_m1_done", 32'(done), 32'b001);
        for (int i = 1; i < m2_edges; i++) begin
            step(2'd2);
            check($sformatf("m2_wait_e%0d", i), 32'(done), 0);
        end
        step(2'd2);
        check("m2_done", 32'(done), 32'b010);
        check("m2_nb", 32'(nb_preempt), 1);
        step(2'd0);

        // M3 aborted, then re-granted needs the full 8 edges
        for (int i = 1; i <= 5; i++) step(2'd3);
        step(2'd0);
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);
        for (int i = 1; i <= 7; i++) begin
            step(2'd3);
            check($sformatf("m3_wait_e%0d", i), 32'(done), 0);
        end
        step(2'd3);
        check("m3_done", 32'(done), 32'b100);
        // DONE_WAIT hold, then switch to another module without a preemption
        step(2'd3);
        check("dw_hold_done", 32'(done), 0);
        check("dw_hold_busy", 32'(busy), 0);
        step(2'd2);
        check("dw_switch_busy", 32'(busy), 1);
        check("dw_switch_nb", 32'(nb_preempt), 1);
        step(2'd0);

        // Length-1 module completes on its first edge then waits
        step_b(2'd1);
        check("short_done_e1", 32'(done_b), 32'b001);
        check("short_busy_e1", 32'(busy_b), 0);
        for (int i = 2; i <= 5; i++) begin
            step_b(2'd1);
            check($sformatf("short_done_e%0d", i), 32'(done_b), 0);
        end
        step_b(2'd0);

        // Alternating M2/M3 grants of two edges each saturate the preemption count
        for (int g = 1; g <= sat_grants; g++) begin
            step((g % 2 == 1) ? 2'd2 : 2'd3);
            step((g % 2 == 1) ? 2'd2 : 2'd3);
            if (g == 10)
                check("sat_nb_g10", 32'(nb_preempt), 32'(nb_after10));
        end
        check("sat_nb", 32'(nb_preempt), 255);
        check("sat_busy", 32'(busy), 1);

        // Asynchronous reset in the middle of an access
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_nb", 32'(nb_preempt), 0);
        @(posedge clk);
        #1;
        accmodule = 2'd0;
        reset = 1'b0;
        step(2'd0);
        check("post_done", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
